// File: rtl/barrier_detector.sv
// Free-direction / hazard / checkpoint producer for the man controller.
// One nine-probe tile-map scan per frame edge, committed atomically.
module barrier_detector #(
  parameter int MAN_W    = 32,
  parameter int MAN_H    = 32,
  parameter int STEP_X   = 2,
  parameter int STEP_UP  = 5,
  parameter int STEP_DN  = 3,
  parameter int MAP_COLS = 20,
  parameter int MAP_ROWS = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] man_x,
  input  logic [9:0] man_y,
  output logic [8:0] tile_addr,
  input  logic [2:0] tile_data,
  output logic [3:0] barrier,
  output logic       dead,
  output logic       check,
  output logic [9:0] map_x,
  output logic [9:0] map_y,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [11:0] XLIM = 12'(MAP_COLS * 32);
  localparam logic [11:0] YLIM = 12'(MAP_ROWS * 32);
  localparam logic [11:0] DR   = 12'(MAN_W - 1);
  localparam logic [11:0] DB   = 12'(MAN_H - 1);
  localparam logic [11:0] DXR  = 12'(MAN_W - 1 + STEP_X);
  localparam logic [11:0] DXL  = 12'(STEP_X);
  localparam logic [11:0] DYU  = 12'(STEP_UP);
  localparam logic [11:0] DYD  = 12'(MAN_H - 1 + STEP_DN);
  localparam logic [11:0] DCX  = 12'(MAN_W / 2);
  localparam logic [11:0] DCY  = 12'(MAN_H / 2);

  // probe class: 0 = read map, 1 = forced solid, 2 = forced empty
  localparam logic [1:0] C_MAP = 2'd0;
  localparam logic [1:0] C_SOL = 2'd1;
  localparam logic [1:0] C_EMP = 2'd2;

  logic [1:0] r_state;
  logic       r_fc_d;
  logic       r_fr;
  logic [9:0] r_px;
  logic [9:0] r_py;
  logic       r_below;
  logic [3:0] r_k;
  logic [1:0] r_cls;
  logic       r_v1;
  logic [3:0] r_k1;
  logic [1:0] r_cls1;
  logic [7:0] r_solid;
  logic [9:0] r_fx;
  logic [9:0] r_fy;

  logic [9:0]  w_bx;
  logic [9:0]  w_by;
  logic [3:0]  w_nk;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic [11:0] w_bx12;
  logic [11:0] w_by12;
  logic        w_oor_s;
  logic        w_oor_e;
  logic [8:0]  w_addr;
  logic        w_sol;
  logic        w_spk;
  logic        w_flg;

  // probe 0 is issued while ARM latches, so it reads the live position
  assign w_bx   = (r_state == S_ARM) ? man_x : r_px;
  assign w_by   = (r_state == S_ARM) ? man_y : r_py;
  assign w_nk   = (r_state == S_ARM) ? 4'd0 : r_k + 4'd1;
  assign w_bx12 = {2'b00, w_bx};
  assign w_by12 = {2'b00, w_by};

  always_comb begin
    w_x = w_bx12;
    w_y = w_by12;
    case (w_nk)
      4'd0: begin w_x = w_bx12 + DXR; w_y = w_by12;      end
      4'd1: begin w_x = w_bx12 + DXR; w_y = w_by12 + DB; end
      4'd2: begin w_x = w_bx12 - DXL; w_y = w_by12;      end
      4'd3: begin w_x = w_bx12 - DXL; w_y = w_by12 + DB; end
      4'd4: begin w_x = w_bx12;       w_y = w_by12 - DYU; end
      4'd5: begin w_x = w_bx12 + DR;  w_y = w_by12 - DYU; end
      4'd6: begin w_x = w_bx12;       w_y = w_by12 + DYD; end
      4'd7: begin w_x = w_bx12 + DR;  w_y = w_by12 + DYD; end
      default: begin w_x = w_bx12 + DCX; w_y = w_by12 + DCY; end
    endcase
  end

  // bit 11 is the sign of the 12-bit probe coordinate
  assign w_oor_s = w_x[11] | (w_x >= XLIM) | w_y[11];
  assign w_oor_e = ~w_oor_s & (w_y >= YLIM);
  assign w_addr  = 9'(int'(w_y[9:5]) * MAP_COLS + int'(w_x[9:5]));

  assign w_sol = (r_cls1 == C_SOL) | ((r_cls1 == C_MAP) & (tile_data == 3'd1));
  assign w_spk = (r_cls1 == C_MAP) & (tile_data == 3'd2);
  assign w_flg = (r_cls1 == C_MAP) & (tile_data == 3'd3);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_fc_d    <= 1'b0;
      r_fr      <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_below   <= 1'b0;
      r_k       <= '0;
      r_cls     <= C_MAP;
      r_v1      <= 1'b0;
      r_k1      <= '0;
      r_cls1    <= C_MAP;
      r_solid   <= '0;
      r_fx      <= '0;
      r_fy      <= '0;
      tile_addr <= '0;
      barrier   <= 4'b0000;
      dead      <= 1'b0;
      check     <= 1'b0;
      map_x     <= 10'd96;
      map_y     <= 10'd192;
      busy      <= 1'b0;
    end else begin
      r_fc_d <= frame_clk;
      r_fr   <= frame_clk & ~r_fc_d;
      check  <= 1'b0;
      r_v1   <= (r_state == S_ISSUE);
      r_k1   <= r_k;
      r_cls1 <= r_cls;
      if (r_v1 && !r_k1[3]) r_solid[r_k1[2:0]] <= w_sol;
      if (r_state == S_ARM || (r_state == S_ISSUE && r_k != 4'd8)) begin
        r_k       <= w_nk;
        tile_addr <= (w_oor_s | w_oor_e) ? 9'd0 : w_addr;
        r_cls     <= w_oor_s ? C_SOL : (w_oor_e ? C_EMP : C_MAP);
        if (w_nk == 4'd8) begin
          r_fx <= {w_x[9:5], 5'b0};
          r_fy <= {w_y[9:5], 5'b0};
        end
      end
      case (r_state)
        S_IDLE: begin
          if (r_fr) begin
            r_state <= S_ARM;
            busy    <= 1'b1;
          end
        end
        S_ARM: begin
          r_px    <= man_x;
          r_py    <= man_y;
          r_below <= ({1'b0, man_y} + 11'(MAN_H - 1)) >= 11'(MAP_ROWS * 32);
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (r_k == 4'd8) r_state <= S_COMMIT;
        end
        default: begin
          barrier <= {~(r_solid[6] | r_solid[7]), ~(r_solid[4] | r_solid[5]),
                      ~(r_solid[2] | r_solid[3]), ~(r_solid[0] | r_solid[1])};
          dead    <= w_spk | r_below;
          if (w_flg) begin
            check <= 1'b1;
            map_x <= r_fx;
            map_y <= r_fy;
          end
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_detector.sv
// Bench for barrier_detector: directed scenarios plus randomized scans
// checked against a probe-list reference model and a tile-map memory.
module tb_barrier_detector;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] man_x = '0;
  logic [9:0] man_y = '0;
  logic [8:0] tile_addr;
  logic [2:0] tile_data = '0;
  logic [3:0] barrier;
  logic       dead;
  logic       check;
  logic [9:0] map_x;
  logic [9:0] map_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] tmap [300];

  logic [8:0] m_addr [9];
  logic [3:0] m_b;
  logic       m_d;
  logic       m_f;
  logic [9:0] m_fx;
  logic [9:0] m_fy;

  logic [3:0] e_b  = 4'b0000;
  logic       e_d  = 1'b0;
  logic [9:0] e_mx = 10'd96;
  logic [9:0] e_my = 10'd192;

  barrier_detector dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .man_x(man_x), .man_y(man_y), .tile_addr(tile_addr),
    .tile_data(tile_data), .barrier(barrier), .dead(dead),
    .check(check), .map_x(map_x), .map_y(map_y), .busy(busy)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk)
    tile_data <= (int'(tile_addr) < 300) ? tmap[tile_addr] : 3'd0;

  task automatic clear_map();
    for (int i = 0; i < 300; i++) tmap[i] = 3'd0;
  endtask

  task automatic rand_map();
    for (int i = 0; i < 300; i++) tmap[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic model_scan(input int px, input int py);
    int xs [9];
    int ys [9];
    int code [9];
    bit sol [9];
    xs = '{px + 33, px + 33, px - 2, px - 2, px, px + 31, px, px + 31, px + 16};
    ys = '{py, py + 31, py, py + 31, py - 5, py - 5, py + 34, py + 34, py + 16};
    for (int i = 0; i < 9; i++) begin
      if (xs[i] < 0 || xs[i] >= 640 || ys[i] < 0) begin
        m_addr[i] = 9'd0;
        code[i] = 1;
      end else if (ys[i] >= 480) begin
        m_addr[i] = 9'd0;
        code[i] = 0;
      end else begin
        m_addr[i] = 9'((ys[i] / 32) * 20 + xs[i] / 32);
        code[i] = int'(tmap[m_addr[i]]);
      end
      sol[i] = (code[i] == 1);
    end
    for (int j = 0; j < 4; j++) m_b[j] = !sol[2 * j] && !sol[2 * j + 1];
    m_d  = (code[8] == 2) || (py + 31 >= 480);
    m_f  = (code[8] == 3);
    m_fx = 10'((xs[8] / 32) * 32);
    m_fy = 10'((ys[8] / 32) * 32);
  endtask

  task automatic do_scan(input int px, input int py, input bit extra);
    man_x = 10'(px);
    man_y = 10'(py);
    model_scan(px, py);
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= 14; n++) begin
      @(posedge Clk); #1;
      checks++;
      if (busy !== (n <= 11)) begin
        errors++; $display("FAIL busy T+%0d: got %0b want %0b", n, busy, n <= 11);
      end
      if (n >= 2 && n <= 10) begin
        checks++;
        if (tile_addr !== m_addr[n - 2]) begin
          errors++;
          $display("FAIL tile_addr probe %0d: got %0d want %0d", n - 2, tile_addr, m_addr[n - 2]);
        end
      end
      if (n == 12) begin
        e_b = m_b;
        e_d = m_d;
        if (m_f) begin e_mx = m_fx; e_my = m_fy; end
      end
      checks++;
      if (check !== (n == 12 && m_f)) begin
        errors++; $display("FAIL check T+%0d: got %0b want %0b", n, check, n == 12 && m_f);
      end
      checks++;
      if (barrier !== e_b || dead !== e_d) begin
        errors++;
        $display("FAIL barrier/dead T+%0d (%0d,%0d): got %b/%0b want %b/%0b",
                 n, px, py, barrier, dead, e_b, e_d);
      end
      checks++;
      if (map_x !== e_mx || map_y !== e_my) begin
        errors++;
        $display("FAIL map T+%0d: got %0d,%0d want %0d,%0d", n, map_x, map_y, e_mx, e_my);
      end
      if (n == 3) begin
        frame_clk = 1'b0;
        man_x = 10'($urandom_range(0, 1023));
        man_y = 10'($urandom_range(0, 1023));
      end
      if (n == 5 && extra) frame_clk = 1'b1;
      if (n == 7) frame_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (barrier !== 4'b0000 || dead !== 1'b0 || check !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got b=%b d=%0b c=%0b busy=%0b want 0000/0/0/0",
               barrier, dead, check, busy);
    end
    checks++;
    if (map_x !== 10'd96 || map_y !== 10'd192 || tile_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset regs: got mx=%0d my=%0d ta=%0d want 96/192/0",
               map_x, map_y, tile_addr);
    end
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic test_row7();
    clear_map();
    for (int c = 0; c < 20; c++) tmap[7 * 20 + c] = 3'd1;
    do_scan(96, 192, 1'b0);
    checks++;
    if (barrier !== 4'b0111) begin
      errors++; $display("FAIL row7 barrier: got %b want 0111", barrier);
    end
  endtask

  task automatic test_left_edge();
    clear_map();
    do_scan(1, 192, 1'b0);
    checks++;
    if (barrier !== 4'b1101) begin
      errors++; $display("FAIL left edge barrier: got %b want 1101", barrier);
    end
  endtask

  task automatic test_spike();
    clear_map();
    tmap[6 * 20 + 3] = 3'd2;
    do_scan(96, 192, 1'b0);
    checks++;
    if (dead !== 1'b1) begin
      errors++; $display("FAIL spike dead: got %0b want 1", dead);
    end
    do_scan(160, 192, 1'b0);
    checks++;
    if (dead !== 1'b0) begin
      errors++; $display("FAIL spike clear: got %0b want 0", dead);
    end
  endtask

  task automatic test_flag();
    clear_map();
    tmap[4 * 20 + 5] = 3'd3;
    do_scan(160, 128, 1'b0);
    tmap[4 * 20 + 5] = 3'd0;
    do_scan(300, 300, 1'b0);
    checks++;
    if (map_x !== 10'd160 || map_y !== 10'd128) begin
      errors++; $display("FAIL flag hold: got %0d,%0d want 160,128", map_x, map_y);
    end
  endtask

  task automatic test_below();
    clear_map();
    do_scan(200, 460, 1'b0);
    checks++;
    if (dead !== 1'b1 || barrier[3] !== 1'b1) begin
      errors++; $display("FAIL below: got d=%0b b3=%0b want 1/1", dead, barrier[3]);
    end
  endtask

  task automatic test_reset_mid_scan();
    clear_map();
    tmap[6 * 20 + 3] = 3'd3;
    man_x = 10'd96;
    man_y = 10'd192;
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= 6; n++) begin
      @(posedge Clk); #1;
      if (n == 3) frame_clk = 1'b0;
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    e_b = 4'b0000; e_d = 1'b0; e_mx = 10'd96; e_my = 10'd192;
    checks++;
    if (barrier !== 4'b0000 || busy !== 1'b0 || map_x !== 10'd96 || map_y !== 10'd192) begin
      errors++;
      $display("FAIL mid reset: got b=%b busy=%0b map=%0d,%0d want 0000/0/96,192",
               barrier, busy, map_x, map_y);
    end
    for (int n = 0; n < 12; n++) begin
      @(posedge Clk); #1;
      checks++;
      if (check !== 1'b0 || busy !== 1'b0 || barrier !== 4'b0000) begin
        errors++;
        $display("FAIL after reset %0d: got c=%0b busy=%0b b=%b want 0/0/0000",
                 n, check, busy, barrier);
      end
    end
    do_scan(96, 192, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      rand_map();
      do_scan(int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_row7();
    test_left_edge();
    test_spike();
    test_flag();
    test_below();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
